// File: rtl/pi_bus_pkg.sv
// Shared types and constants for the N64 PI bus initiator (pi_bus_master).
package pi_bus_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned HW_W        = 16;
    localparam int unsigned LEN_W       = 8;
    localparam int unsigned CFG_W       = 8;
    localparam int unsigned CFG_MAX     = 255;
    localparam int unsigned MIN_STROBE  = 3;
    localparam int unsigned ADDR_HI_LSB = 16;
    // Halfword-aligned bus address: bit 0 never reaches the AD bus.
    localparam logic [ADDR_W-1:0] ADDR_HW_MASK = 32'hFFFF_FFFE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_SETTLE,
        ST_STROBE,
        ST_RELEASE
    } pi_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
    } pi_req_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [CFG_W-1:0] clamp_strobe(input logic [CFG_W-1:0] v);
        return (v < CFG_W'(MIN_STROBE)) ? CFG_W'(MIN_STROBE) : v;
    endfunction

endpackage

// File: rtl/pi_phase_timer.sv
// Loadable down-counter shared by every PI bus phase; done_c marks the last cycle of a phase.
module pi_phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         cold_reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c,
    output logic         almost_c
);

    logic [W-1:0] cnt;

    // A load of N yields N cycles with the final one flagged by done_c; holds at zero.
    always_ff @(posedge clk or negedge cold_reset) begin
        if (!cold_reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done_c   = (cnt == '0);
    assign almost_c = (cnt <= W'(1));

endmodule

// File: rtl/pi_bus_master.sv
// N64 PI bus initiator: ALEH/ALEL address phases then READ/WRITE halfword strobes.
// Optional macro PI_TIMING_CFG_EN adds per-burst cfg_pulse/cfg_release timing inputs.
module pi_bus_master
    import pi_bus_pkg::*;
#(
    parameter int unsigned T_ALE     = 4,
    parameter int unsigned T_SETTLE  = 4,
    parameter int unsigned T_PULSE   = 6,
    parameter int unsigned T_RELEASE = 4
) (
    input  logic              clk,
    input  logic              cold_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [HW_W-1:0]   wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [HW_W-1:0]   rd_data,
    output logic              rd_valid,
    output logic              busy,
    input  logic [HW_W-1:0]   ad_in,
`ifdef PI_TIMING_CFG_EN
    input  logic [CFG_W-1:0]  cfg_pulse,
    input  logic [CFG_W-1:0]  cfg_release,
`endif
    output logic [HW_W-1:0]   ad_out,
    output logic              ad_oe,
    output logic              aleh,
    output logic              alel,
    output logic              read_n,
    output logic              write_n
);

    localparam int unsigned PULSE_DEF = max2(T_PULSE, MIN_STROBE);
    localparam int unsigned REL_DEF   = max2(T_RELEASE, MIN_STROBE);
    localparam int unsigned T_MAX     = max2(max2(T_ALE, T_SETTLE), max2(PULSE_DEF, REL_DEF));
`ifdef PI_TIMING_CFG_EN
    localparam int unsigned CNT_W     = $clog2(max2(T_MAX, CFG_MAX)) + 1;
`else
    localparam int unsigned CNT_W     = $clog2(T_MAX) + 1;
`endif

    pi_state_e        state_q, state_d;
    pi_req_t          req_q, req_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [HW_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0] pulse_len, rel_len, tmr_val;
    logic             tmr_load, tmr_done_c, tmr_almost_c, nxt_done;
    logic             accept_c, take_c;
    logic             aleh_d, alel_d, read_n_d, write_n_d, ad_oe_d, wr_ready_d, rd_valid_d;
    logic [HW_W-1:0]  ad_out_d;

    assign accept_c = req_valid && req_ready;
    assign take_c   = wr_valid && wr_ready;

`ifdef PI_TIMING_CFG_EN
    logic [CNT_W-1:0] pulse_q, rel_q;

    // Strobe timing is frozen at request acceptance for the whole burst.
    always_ff @(posedge clk or negedge cold_reset) begin
        if (!cold_reset) begin
            pulse_q <= CNT_W'(PULSE_DEF);
            rel_q   <= CNT_W'(REL_DEF);
        end else if (accept_c) begin
            pulse_q <= CNT_W'(clamp_strobe(cfg_pulse));
            rel_q   <= CNT_W'(clamp_strobe(cfg_release));
        end
    end

    assign pulse_len = pulse_q;
    assign rel_len   = rel_q;
`else
    assign pulse_len = CNT_W'(PULSE_DEF);
    assign rel_len   = CNT_W'(REL_DEF);
`endif

    pi_phase_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .cold_reset (cold_reset),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .done_c     (tmr_done_c),
        .almost_c   (tmr_almost_c)
    );

    // Next state, then next values of the registered bus outputs for that state.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        rem_d      = rem_q;
        wdata_d    = wdata_q;
        tmr_val    = '0;
        aleh_d     = 1'b0;
        alel_d     = 1'b0;
        read_n_d   = 1'b1;
        write_n_d  = 1'b1;
        ad_oe_d    = 1'b0;
        ad_out_d   = '0;
        wr_ready_d = 1'b0;
        rd_valid_d = (state_q == ST_STROBE) && !req_q.write && tmr_done_c;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    req_d.write = req_write;
                    req_d.addr  = req_addr & ADDR_HW_MASK;
                    rem_d       = req_len;
                    state_d     = ST_ADDR_HI;
                end
            end
            ST_ADDR_HI: if (tmr_done_c) state_d = ST_ADDR_LO;
            ST_ADDR_LO: if (tmr_done_c) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (tmr_done_c && (!req_q.write || take_c)) state_d = ST_STROBE;
            end
            ST_STROBE: if (tmr_done_c) state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (tmr_done_c) begin
                    if (rem_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (!req_q.write || take_c) begin
                        rem_d   = rem_q - LEN_W'(1);
                        state_d = ST_STROBE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_c) wdata_d = wr_data;

        tmr_load = (state_d != state_q);
        case (state_d)
            ST_ADDR_HI, ST_ADDR_LO: tmr_val = CNT_W'(T_ALE);
            ST_SETTLE:              tmr_val = CNT_W'(T_SETTLE);
            ST_STROBE:              tmr_val = pulse_len;
            ST_RELEASE:             tmr_val = rel_len;
            default:                tmr_val = '0;
        endcase
        // Predicts whether the coming cycle is the last of its phase, so wr_ready lands on it.
        nxt_done = tmr_load ? (tmr_val <= CNT_W'(1)) : tmr_almost_c;

        case (state_d)
            ST_ADDR_HI: begin
                aleh_d   = 1'b1;
                alel_d   = 1'b1;
                ad_oe_d  = 1'b1;
                ad_out_d = req_d.addr[ADDR_W-1:ADDR_HI_LSB];
            end
            ST_ADDR_LO: begin
                alel_d   = 1'b1;
                ad_oe_d  = 1'b1;
                ad_out_d = req_d.addr[ADDR_HI_LSB-1:0];
            end
            ST_SETTLE: wr_ready_d = req_d.write && nxt_done;
            ST_STROBE: begin
                if (req_d.write) begin
                    write_n_d = 1'b0;
                    ad_oe_d   = 1'b1;
                    ad_out_d  = wdata_d;
                end else begin
                    read_n_d  = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (req_d.write) begin
                    if (state_q == ST_STROBE) begin
                        ad_oe_d  = 1'b1;
                        ad_out_d = wdata_q;
                    end
                    wr_ready_d = nxt_done && (rem_d != '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge cold_reset) begin
        if (!cold_reset) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            rem_q     <= '0;
            wdata_q   <= '0;
            aleh      <= 1'b0;
            alel      <= 1'b0;
            read_n    <= 1'b1;
            write_n   <= 1'b1;
            ad_oe     <= 1'b0;
            ad_out    <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b0;
            rd_data   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            rem_q     <= rem_d;
            wdata_q   <= wdata_d;
            aleh      <= aleh_d;
            alel      <= alel_d;
            read_n    <= read_n_d;
            write_n   <= write_n_d;
            ad_oe     <= ad_oe_d;
            ad_out    <= ad_out_d;
            req_ready <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            rd_valid  <= rd_valid_d;
            wr_ready  <= wr_ready_d;
            if (rd_valid_d) rd_data <= ad_in;
        end
    end

endmodule

// File: tb/tb_pi_bus_master.sv
// Scoreboard bench for pi_bus_master: bus monitor, read-data bus model and write-data feeder.
module tb_pi_bus_master;

    logic        clk = 1'b0;
    logic        cold_reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid, busy;
    logic [15:0] ad_in = '0, ad_out;
    logic        ad_oe, aleh, alel, read_n, write_n;
`ifdef PI_TIMING_CFG_EN
    logic [7:0]  cfg_pulse = 8'd6, cfg_release = 8'd4;
`endif

    pi_bus_master dut (
        .clk        (clk),
        .cold_reset (cold_reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .ad_in      (ad_in),
`ifdef PI_TIMING_CFG_EN
        .cfg_pulse  (cfg_pulse),
        .cfg_release(cfg_release),
`endif
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .aleh       (aleh),
        .alel       (alel),
        .read_n     (read_n),
        .write_n    (write_n)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard queues
    logic [15:0] stim[$];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] bus_rd[$];
    logic [15:0] wr_src[$];

    // Per-burst tracking
    bit cur_wr;
    bit chk_gap;
    int exp_pulse = 6, exp_gap = 4;
    int stall_idx = -1;
    int wr_taken, wr_hold;
    int rd_pulses, wr_pulses, rdv_cnt, wrr_pulses, stall_cyc;

    // Write-data feeder: presents wr_src[0], pops after each handshake, optionally withholds.
    initial begin
        bit hs;
        hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!cold_reset) begin
                hs = 1'b0;
                wr_valid = 1'b0;
            end else begin
                if (hs) begin
                    if (wr_src.size() != 0) void'(wr_src.pop_front());
                    wr_taken++;
                    if (wr_taken == stall_idx) wr_hold = 20;
                end
                if (wr_hold > 0) begin
                    wr_hold--;
                    wr_valid = 1'b0;
                end else begin
                    wr_valid = (wr_src.size() != 0);
                    wr_data  = (wr_src.size() != 0) ? wr_src[0] : 16'h0000;
                end
                hs = wr_valid && wr_ready;
            end
        end
    end

    // Bus monitor and read-data bus model.
    initial begin
        bit strobe_prev, aleh_prev, rdv_prev, wrr_prev, seen_strobe, strobe_low;
        int low_run, high_run;
        logic [15:0] w;
        strobe_prev = 1'b1; aleh_prev = 1'b0; rdv_prev = 1'b0; wrr_prev = 1'b0;
        seen_strobe = 1'b0; low_run = 0; high_run = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!cold_reset) begin
                strobe_prev = 1'b1; aleh_prev = 1'b0; rdv_prev = 1'b0; wrr_prev = 1'b0;
                seen_strobe = 1'b0; low_run = 0; high_run = 0;
            end else begin
                if ((aleh && !aleh_prev) || (!aleh && aleh_prev && alel)) begin
                    if (exp_addr.size() == 0) check_eq("addr_extra", exp_addr.size(), 1);
                    else begin
                        w = exp_addr.pop_front();
                        check_eq(aleh ? "addr_hi" : "addr_lo", {ad_oe, ad_out}, {1'b1, w});
                    end
                end
                if (aleh) check_eq("ale_order", alel, 1);
                if (!read_n) check_eq("strobe_excl", write_n, 1);

                strobe_low = !read_n || !write_n;
                if (strobe_low && strobe_prev) begin
                    if (seen_strobe && chk_gap) check_eq("gap_width", high_run, exp_gap);
                    seen_strobe = 1'b1;
                    low_run = 1;
                    if (!write_n) begin
                        wr_pulses++;
                        if (exp_wr.size() == 0) check_eq("wr_extra", exp_wr.size(), 1);
                        else begin
                            w = exp_wr.pop_front();
                            check_eq("wr_data", {ad_oe, ad_out}, {1'b1, w});
                        end
                    end else begin
                        rd_pulses++;
                        if (bus_rd.size() != 0) ad_in = bus_rd.pop_front();
                    end
                end else if (strobe_low) begin
                    low_run++;
                end else if (!strobe_prev) begin
                    check_eq("pulse_width", low_run, exp_pulse);
                    high_run = 1;
                end else begin
                    high_run++;
                end

                if (rd_valid) begin
                    rdv_cnt++;
                    check_eq("rd_valid_pulse", rdv_prev, 0);
                    if (exp_rd.size() == 0) check_eq("rd_extra", exp_rd.size(), 1);
                    else begin
                        w = exp_rd.pop_front();
                        check_eq("rd_data", rd_data, w);
                    end
                end
                if (wr_ready && !wrr_prev) wrr_pulses++;
                if (wr_ready && !wr_valid) begin
                    stall_cyc++;
                    check_eq("stall_bus", {write_n, ad_oe}, 2'b10);
                end
                if (!busy) seen_strobe = 1'b0;

                strobe_prev = !strobe_low;
                aleh_prev   = aleh;
                rdv_prev    = rd_valid;
                wrr_prev    = wr_ready;
            end
        end
    end

    task automatic start_burst(input bit wr, input logic [31:0] addr, input int len,
                               input int pulse, input int gap, input bit gapchk, input int stall_at);
        logic [15:0] w;
        int n;
        cur_wr = wr; exp_pulse = pulse; exp_gap = gap; chk_gap = gapchk; stall_idx = stall_at;
        wr_taken = 0; wr_hold = 0;
        rd_pulses = 0; wr_pulses = 0; rdv_cnt = 0; wrr_pulses = 0; stall_cyc = 0;
        exp_addr.push_back(addr[31:16]);
        exp_addr.push_back({addr[15:1], 1'b0});
        for (int i = 0; i <= len; i++) begin
            w = (stim.size() != 0) ? stim.pop_front() : 16'(i);
            if (wr) begin
                wr_src.push_back(w);
                exp_wr.push_back(w);
            end else begin
                bus_rd.push_back(w);
                exp_rd.push_back(w);
            end
        end
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_idle", req_ready, 1);
        req_write = wr;
        req_addr  = addr;
        req_len   = 8'(len);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        check_eq("busy_start", {busy, req_ready}, 2'b10);
    endtask

    task automatic finish_burst(input int len);
        int n, limit;
        limit = 60 + (len + 1) * (exp_pulse + exp_gap + 2) + ((stall_idx > 0) ? 40 : 0);
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_eq("burst_end", {busy, req_ready}, 2'b01);
        @(negedge clk);
        #2;
        check_eq("strobe_cnt", cur_wr ? wr_pulses : rd_pulses, len + 1);
        check_eq("other_strobe", cur_wr ? rd_pulses : wr_pulses, 0);
        check_eq("rd_valid_cnt", rdv_cnt, cur_wr ? 0 : len + 1);
        check_eq("wr_ready_pulses", wrr_pulses, cur_wr ? len + 1 : 0);
        check_eq("stall_seen", (stall_cyc >= 5), (stall_idx > 0));
        check_eq("sb_empty", exp_addr.size() + exp_wr.size() + exp_rd.size(), 0);
    endtask

    initial begin
        int n;
        // Reset values
        repeat (3) @(negedge clk);
        #2;
        check_eq("reset_ctl", {aleh, alel, read_n, write_n, ad_oe, req_ready, busy, rd_valid, wr_ready},
                 9'b001101000);
        check_eq("reset_data", {ad_out, rd_data}, 32'h0);
        @(negedge clk);
        cold_reset = 1'b1;

        // Single read with a known bus value
        stim.push_back(16'hA5C3);
        start_burst(1'b0, 32'h1000_0040, 0, 6, 4, 1'b1, -1);
        finish_burst(0);
        check_eq("rd_data_hold", rd_data, 16'hA5C3);

        // Four-halfword write
        stim.push_back(16'h0600); stim.push_back(16'h0400);
        stim.push_back(16'h0000); stim.push_back(16'hFFFF);
        start_burst(1'b1, 32'h1E40_0800, 3, 6, 4, 1'b1, -1);
        finish_burst(3);

        // Write with data withheld before the second halfword
        for (int i = 0; i < 4; i++) stim.push_back(16'($urandom));
        start_burst(1'b1, 32'h1E40_0900, 3, 6, 4, 1'b0, 1);
        finish_burst(3);

        // Maximum-length read; a request during the burst must be ignored
        for (int i = 0; i < 256; i++) stim.push_back(16'($urandom));
        start_burst(1'b0, 32'h1000_1000, 255, 6, 4, 1'b1, -1);
        repeat (30) @(negedge clk);
        req_addr  = 32'h0BAD_0000;
        req_valid = 1'b1;
        check_eq("req_ready_busy", req_ready, 0);
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        finish_burst(255);

        // Reset during the third write strobe
        for (int i = 0; i < 8; i++) stim.push_back(16'h1000 + 16'(i));
        start_burst(1'b1, 32'h1E40_0A00, 7, 6, 4, 1'b1, -1);
        n = 0;
        while (wr_pulses < 3 && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_eq("reach_strobe3", wr_pulses, 3);
        cold_reset = 1'b0;
        #1;
        check_eq("abort_bus", {write_n, read_n, ad_oe, aleh, alel}, 5'b11000);
        check_eq("abort_ctl", {busy, req_ready, wr_ready, rd_valid}, 4'b0100);
        exp_wr.delete(); wr_src.delete(); exp_addr.delete(); exp_rd.delete(); bus_rd.delete();
        repeat (2) @(negedge clk);
        cold_reset = 1'b1;

        // Clean restart; odd address has bit 0 dropped on the bus
        stim.push_back(16'h1234); stim.push_back(16'hBEEF);
        start_burst(1'b0, 32'h1000_0043, 1, 6, 4, 1'b1, -1);
        finish_burst(1);

`ifdef PI_TIMING_CFG_EN
        // Per-burst timing with a clamped pulse width
        cfg_pulse   = 8'd1;
        cfg_release = 8'd10;
        stim.push_back(16'h0F0F); stim.push_back(16'hF0F0); stim.push_back(16'h5A5A);
        start_burst(1'b0, 32'h1000_2000, 2, 3, 10, 1'b1, -1);
        finish_burst(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
